// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input and program-memory load port of the loader.
interface prog_loader_if #(
    parameter int ADDR_W = 8,
    parameter int INST_W = 12
);
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              LE;
    logic [ADDR_W-1:0] LA;
    logic [INST_W-1:0] LI;
    logic              busy;
    logic              done;
    logic              err;
    logic              cpu_hold;
    modport master (
        output start, in_valid, in_data,
        input  in_ready, LE, LA, LI, busy, done, err, cpu_hold
    );
    modport slave (
        input  start, in_valid, in_data,
        output in_ready, LE, LA, LI, busy, done, err, cpu_hold
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: packs a framed byte stream (LEN, LEN x {HI,LO}, CSUM) into program-memory writes.
module prog_loader #(
    parameter int ADDR_W    = 8,
    parameter int INST_W    = 12,
    parameter int BASE_ADDR = 0
) (
    input logic           clk,
    input logic           rst_n,
    prog_loader_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, LEN, HI, LO, WR, CSUM, DONE, ERR} state_t;
    // count is wide enough to hold 2^ADDR_W, which LEN=0 stands for
    localparam int CW = (ADDR_W > 8 ? ADDR_W : 8) + 1;
    localparam logic [CW-1:0] FULL = CW'(1) << ADDR_W;
    state_t              state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [7:0]          sum_q, sum_d;
    logic [INST_W-9:0]   hi_q, hi_d;
    logic [ADDR_W-1:0]   la_q, la_d;
    logic [INST_W-1:0]   li_q, li_d;
    logic                in_ready_q, in_ready_d;
    logic                le_q, le_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                xfer;
    assign xfer = bus.in_valid && in_ready_q;
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hi_d    = hi_q;
        la_d    = la_q;
        li_d    = li_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        sum_d   = xfer ? sum_q + bus.in_data : sum_q;
        case (state_q)
            IDLE, DONE, ERR: if (bus.start) begin
                state_d = LEN;
                done_d  = 1'b0;
                err_d   = 1'b0;
                sum_d   = 8'd0;
                la_d    = ADDR_W'(BASE_ADDR);
                busy_d  = 1'b1;
            end
            LEN: if (xfer) begin
                count_d = bus.in_data == 8'd0 ? FULL : CW'(bus.in_data);
                state_d = HI;
            end
            HI: if (xfer) begin
                if ((bus.in_data >> (INST_W - 8)) != 8'd0) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    hi_d    = bus.in_data[INST_W-9:0];
                    state_d = LO;
                end
            end
            LO: if (xfer) begin
                li_d    = {hi_q, bus.in_data};
                state_d = WR;
            end
            WR: begin
                la_d    = la_q + 1'b1;
                count_d = count_q - 1'b1;
                state_d = count_q == CW'(1) ? CSUM : HI;
            end
            CSUM: if (xfer) begin
                state_d = sum_d == 8'd0 ? DONE : ERR;
                done_d  = sum_d == 8'd0;
                err_d   = sum_d != 8'd0;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = state_d inside {LEN, HI, LO, CSUM};
        le_d       = state_d == WR;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            sum_q      <= '0;
            hi_q       <= '0;
            la_q       <= ADDR_W'(BASE_ADDR);
            li_q       <= '0;
            in_ready_q <= 1'b0;
            le_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            sum_q      <= sum_d;
            hi_q       <= hi_d;
            la_q       <= la_d;
            li_q       <= li_d;
            in_ready_q <= in_ready_d;
            le_q       <= le_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end
    assign bus.in_ready = in_ready_q;
    assign bus.LE       = le_q;
    assign bus.LA       = la_q;
    assign bus.LI       = li_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.cpu_hold = busy_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: random framed streams vs. a frame-parsing reference model, writes checked by a scoreboard.
module tb_prog_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    prog_loader_if #(.ADDR_W(8), .INST_W(12)) bus();
    prog_loader #(.ADDR_W(8), .INST_W(12), .BASE_ADDR(0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int n_chk = 0;
    int n_fail = 0;
    logic [7:0]  exp_la[$];
    logic [11:0] exp_li[$];
    logic [7:0]  fr[$];
    logic [11:0] ins[$];
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (rst_n && bus.LE) begin
            if (exp_la.size() == 0) check("unexpected LE", 1, 0);
            else begin
                check("LA", bus.LA, exp_la.pop_front());
                check("LI", bus.LI, exp_li.pop_front());
            end
            check("in_ready in WR", bus.in_ready, 0);
        end
    end
    // Reference: parse the frame by its rules, queue expected writes, report consumed bytes and outcome.
    task automatic model(output int used, output logic ed, output logic ee);
        int n, s, idx;
        n = fr[0] == 8'd0 ? 256 : int'(fr[0]);
        s = fr[0];
        idx = 1;
        ed = 0;
        ee = 0;
        for (int i = 0; i < n; i++) begin
            s += fr[idx];
            if (fr[idx] > 8'h0F) begin
                used = idx + 1;
                ee = 1;
                return;
            end
            s += fr[idx+1];
            exp_la.push_back(8'(i));
            exp_li.push_back({fr[idx][3:0], fr[idx+1]});
            idx += 2;
        end
        s += fr[idx];
        used = idx + 1;
        ed = (s % 256) == 0;
        ee = !ed;
    endtask
    task automatic build(input logic [7:0] len);
        int s;
        fr = {};
        fr.push_back(len);
        s = len;
        foreach (ins[i]) begin
            fr.push_back({4'h0, ins[i][11:8]});
            fr.push_back(ins[i][7:0]);
            s += ins[i][11:8] + ins[i][7:0];
        end
        fr.push_back(8'(256 - s % 256));
    endtask
    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit mid);
        int n = 0;
        while (gaps && $urandom_range(0, 2) == 0) begin
            bus.in_valid = 0;
            bus.in_data = 8'($urandom);
            bus.start = mid && $urandom_range(0, 3) == 0;
            @(negedge clk);
        end
        bus.start = 0;
        bus.in_valid = 1;
        bus.in_data = b;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("in_ready timeout", 0, 1);
        @(negedge clk);
        bus.in_valid = 0;
    endtask
    task automatic run_frame(input string tag, input bit gaps, input bit mid);
        int used, n;
        logic ed, ee;
        model(used, ed, ee);
        bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        check({tag, " busy after start"}, bus.busy, 1);
        check({tag, " cpu_hold after start"}, bus.cpu_hold, 1);
        check({tag, " flags cleared"}, {bus.done, bus.err}, 0);
        for (int i = 0; i < used; i++) send_byte(fr[i], gaps, mid);
        n = 0;
        while (bus.busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check({tag, " done"}, bus.done, ed);
        check({tag, " err"}, bus.err, ee);
        check({tag, " busy"}, bus.busy, 0);
        check({tag, " cpu_hold"}, bus.cpu_hold, 0);
        check({tag, " writes outstanding"}, exp_la.size(), 0);
        exp_la = {};
        exp_li = {};
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end
    initial begin
        int k;
        bus.start = 0;
        bus.in_valid = 0;
        bus.in_data = 0;
        repeat (2) @(negedge clk);
        check("reset flags", {bus.in_ready, bus.LE, bus.busy, bus.done, bus.err, bus.cpu_hold}, 0);
        check("reset LA", bus.LA, 0);
        check("reset LI", bus.LI, 0);
        rst_n = 1;
        @(negedge clk);
        exp_la.push_back(8'h00);
        exp_li.push_back(12'h005);
        bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        send_byte(8'h01, 0, 0);
        send_byte(8'h00, 0, 0);
        send_byte(8'h05, 0, 0);
        check("LE in WR", bus.LE, 1);
        #2 rst_n = 0;
        #1 check("LE async drop", bus.LE, 0);
        check("busy async drop", bus.busy, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("post-reset flags", {bus.in_ready, bus.LE, bus.busy, bus.done, bus.err}, 0);
        check("post-reset LA", bus.LA, 0);
        exp_la = {};
        exp_li = {};
        fr = {8'h02, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h14};
        run_frame("load", 0, 0);
        fr = {8'h01, 8'h00, 8'hFF, 8'hFF};
        run_frame("bad csum", 0, 0);
        fr = {8'h01, 8'hF0};
        run_frame("bad hi", 0, 0);
        fr = {8'h01, 8'h00, 8'h01, 8'hFE};
        run_frame("restart", 0, 0);
        fr = {8'h02, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h14};
        run_frame("stall load", 1, 0);
        for (int t = 0; t < 10; t++) begin
            ins = {};
            k = $urandom_range(1, 6);
            for (int i = 0; i < k; i++) ins.push_back(12'($urandom));
            build(8'(k));
            case ($urandom_range(0, 3))
                0: fr[fr.size()-1] = fr[fr.size()-1] + 8'($urandom_range(1, 255));
                1: begin
                    k = 1 + 2 * $urandom_range(0, k - 1);
                    fr[k] = fr[k] | (8'h10 << $urandom_range(0, 3));
                end
                default: ;
            endcase
            run_frame("random", 1, 1);
        end
        ins = {};
        for (int i = 0; i < 256; i++) ins.push_back({4'(i), 8'(i)});
        build(8'h00);
        run_frame("len0", 1, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
